// File: rtl/mem_stage_ctrl_if.sv
// Data-memory handshake bundle between the MEM-stage controller and the data memory.
//   dmem_req   : access request (controller -> memory)
//   dmem_we    : write enable qualifying dmem_req (controller -> memory)
//   dmem_ready : memory completes the current access this cycle (memory -> controller)
//   dmem_rdata : read data, valid when dmem_ready=1 (memory -> controller)
// master = controller side, slave = memory side.
interface mem_stage_ctrl_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic              dmem_req;
  logic              dmem_we;
  logic              dmem_ready;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    input  dmem_ready,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    output dmem_ready,
    output dmem_rdata
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory access sequencer for the 5-stage MIPS pipeline.
// Issues a req/ready handshake for each load/store, stalls the upstream pipeline registers while
// the access is outstanding, bubbles MEM/WB during the stall and presents the captured read data
// in a one-cycle release slot. A memory that stays silent for TIMEOUT busy cycles parks the block
// in a sticky error state until reset.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   mem_read_M      : load in MEM stage
//   mem_write_M     : store in MEM stage (wins when both are set)
//   dmem            : data-memory handshake (master side)
//   stall           : hold PC, IF/ID, ID/EX, EX/MEM
//   mem_wb_bubble   : force MEM/WB control bits to zero
//   ReadData_M      : buffered read data to MEM/WB
//   timeout_err     : sticky memory-timeout flag
module mem_stage_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_read_M,
  input  logic               mem_write_M,
  mem_stage_ctrl_if.master   dmem,
  output logic               stall,
  output logic               mem_wb_bubble,
  output logic [DATA_W-1:0]  ReadData_M,
  output logic               timeout_err
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StRelease, StError} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              err_q, err_d;

  logic acc;
  assign acc = mem_read_M | mem_write_M;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (acc) begin
          state_d = StBusy;
          we_d    = mem_write_M;
          cnt_d   = '0;
        end
      end
      StBusy: begin
        if (dmem.dmem_ready) begin
          // Completion beats timeout when both land on the same cycle.
          state_d = StRelease;
          if (!we_q) rdata_d = dmem.dmem_rdata;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CntLast) begin
            state_d = StError;
            err_d   = 1'b1;
          end
        end
      end
      StRelease: state_d = StIdle;
      StError:   state_d = StError;
      default:   state_d = StIdle;
    endcase
  end

  // Output decode. Gated by rst_n so a request held in EX/MEM cannot re-raise dmem_req
  // while reset is still asserted.
  always_comb begin
    dmem.dmem_req = 1'b0;
    dmem.dmem_we  = 1'b0;
    stall         = 1'b0;
    mem_wb_bubble = 1'b0;
    if (rst_n) begin
      case (state_q)
        StIdle: begin
          if (acc) begin
            dmem.dmem_req = 1'b1;
            dmem.dmem_we  = mem_write_M;
            stall         = 1'b1;
            mem_wb_bubble = 1'b1;
          end
        end
        StBusy: begin
          dmem.dmem_req = 1'b1;
          dmem.dmem_we  = we_q;
          stall         = 1'b1;
          mem_wb_bubble = 1'b1;
        end
        StError: begin
          stall         = 1'b1;
          mem_wb_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ReadData_M  = rdata_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 16;

  logic              clk;
  logic              rst_n;
  logic              mem_read_M;
  logic              mem_write_M;
  logic              stall;
  logic              mem_wb_bubble;
  logic [DATA_W-1:0] ReadData_M;
  logic              timeout_err;

  mem_stage_ctrl_if #(.DATA_W(DATA_W)) dmem_bus ();

  mem_stage_ctrl #(
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read_M   (mem_read_M),
    .mem_write_M  (mem_write_M),
    .dmem         (dmem_bus.master),
    .stall        (stall),
    .mem_wb_bubble(mem_wb_bubble),
    .ReadData_M   (ReadData_M),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: the value a completed load leaves in the read buffer.
  logic [DATA_W-1:0] model_buf;

  logic [4:0] obs;
  assign obs = {dmem_bus.dmem_req, dmem_bus.dmem_we, stall, mem_wb_bubble, timeout_err};

  // Expected {req, we, stall, bubble, err} for cycle i of one access, counted from the IDLE
  // accept cycle. A memory answering after `waits` silent cycles finishes if waits < TIMEOUT,
  // otherwise the access times out after TIMEOUT busy cycles.
  function automatic logic [4:0] model_ctl(input bit wr, input int waits, input int i);
    int n_busy;
    n_busy = (waits < int'(TIMEOUT)) ? waits + 1 : int'(TIMEOUT);
    if (i <= n_busy) return {1'b1, wr, 1'b1, 1'b1, 1'b0};
    if (waits < int'(TIMEOUT)) return 5'b00000;
    return 5'b00111;
  endfunction

  task automatic apply_reset();
    rst_n       = 1'b0;
    mem_read_M  = 1'b0;
    mem_write_M = 1'b0;
    dmem_bus.dmem_ready = 1'b0;
    dmem_bus.dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    model_buf = '0;
  endtask

  // Runs one access from the IDLE accept cycle through release (or first error cycle).
  // Entered and left 1 time unit after a rising edge.
  task automatic run_txn(input bit rd, input bit wr, input int waits,
                         input logic [DATA_W-1:0] data, input string tag);
    int n_busy;
    int last;
    logic [4:0] exp_ctl;
    n_busy = (waits < int'(TIMEOUT)) ? waits + 1 : int'(TIMEOUT);
    last   = n_busy + 1;
    for (int i = 0; i <= last; i++) begin
      mem_read_M  = rd;
      mem_write_M = wr;
      if (i >= 1 && i <= n_busy) begin
        dmem_bus.dmem_ready = (waits < int'(TIMEOUT)) && (i == waits + 1);
      end else begin
        dmem_bus.dmem_ready = 1'($urandom_range(0, 1));
      end
      dmem_bus.dmem_rdata = dmem_bus.dmem_ready && i <= n_busy ? data : DATA_W'($urandom);
      if (i == last && waits < int'(TIMEOUT) && rd && !wr) model_buf = data;
      @(negedge clk);
      exp_ctl = model_ctl(wr, waits, i);
      checks++;
      if (obs !== exp_ctl) begin
        errors++;
        $display("FAIL %s cycle %0d ctl: got %b want %b (req,we,stall,bubble,err)",
                 tag, i, obs, exp_ctl);
      end
      if (i == last && waits < int'(TIMEOUT)) begin
        checks++;
        if (ReadData_M !== model_buf) begin
          errors++;
          $display("FAIL %s release data: got %h want %h", tag, ReadData_M, model_buf);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      mem_read_M  = 1'b0;
      mem_write_M = 1'b0;
      dmem_bus.dmem_ready = 1'($urandom_range(0, 1));
      dmem_bus.dmem_rdata = DATA_W'($urandom);
      @(negedge clk);
      checks++;
      if (obs !== 5'b00000 || ReadData_M !== model_buf) begin
        errors++;
        $display("FAIL %s idle: ctl %b want 00000, data %h want %h",
                 tag, obs, ReadData_M, model_buf);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    mem_read_M  = 1'b1;
    mem_write_M = 1'b0;
    dmem_bus.dmem_ready = 1'b0;
    dmem_bus.dmem_rdata = '0;
    #3;
    checks++;
    if (obs !== 5'b00000 || ReadData_M !== '0) begin
      errors++;
      $display("FAIL reset outputs: ctl %b data %h want 00000 / 0", obs, ReadData_M);
    end
    apply_reset();
    idle_cycles(2, "post_reset");
  endtask

  task automatic test_load_fast();
    run_txn(1'b1, 1'b0, 0, 32'hDEADBEEF, "load_fast");
    idle_cycles(1, "load_fast");
  endtask

  task automatic test_store_wait();
    run_txn(1'b0, 1'b1, 5, 32'hCAFEF00D, "store_wait");
    idle_cycles(1, "store_wait");
    run_txn(1'b1, 1'b1, 2, 32'h0BADF00D, "rd_wr_both");
    idle_cycles(1, "rd_wr_both");
  endtask

  task automatic test_ready_at_limit();
    run_txn(1'b1, 1'b0, int'(TIMEOUT) - 1, 32'h5A5A1234, "ready_at_limit");
    idle_cycles(1, "ready_at_limit");
  endtask

  task automatic test_back_to_back();
    run_txn(1'b1, 1'b0, 1, 32'h11111111, "b2b_first");
    run_txn(1'b1, 1'b0, 0, 32'h22222222, "b2b_second");
    idle_cycles(1, "b2b");
  endtask

  task automatic test_timeout();
    run_txn(1'b1, 1'b0, int'(TIMEOUT), 32'h12345678, "timeout");
    for (int i = 0; i < 4; i++) begin
      mem_read_M  = 1'($urandom_range(0, 1));
      mem_write_M = 1'($urandom_range(0, 1));
      dmem_bus.dmem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (obs !== 5'b00111) begin
        errors++;
        $display("FAIL timeout sticky cycle %0d: got %b want 00111", i, obs);
      end
      @(posedge clk);
      #1;
    end
    apply_reset();
    idle_cycles(1, "after_timeout_reset");
  endtask

  task automatic test_reset_mid_busy();
    mem_read_M  = 1'b1;
    mem_write_M = 1'b0;
    dmem_bus.dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 5'b10110) begin
        errors++;
        $display("FAIL reset_mid pre cycle %0d: got %b want 10110", i, obs);
      end
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 5'b00000) begin
      errors++;
      $display("FAIL reset_mid async drop: got %b want 00000", obs);
    end
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    mem_read_M  = 1'b0;
    model_buf   = '0;
    idle_cycles(1, "reset_mid_idle");
    // A fresh counter must let the full TIMEOUT window elapse.
    run_txn(1'b1, 1'b0, int'(TIMEOUT) - 1, 32'hA5A5A5A5, "reset_mid_cnt");
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      int sel;
      bit rd;
      bit wr;
      sel = int'($urandom_range(0, 2));
      rd  = (sel != 1);
      wr  = (sel != 0);
      run_txn(rd, wr, int'($urandom_range(0, 8)), DATA_W'($urandom), "random");
      idle_cycles(int'($urandom_range(0, 2)), "random");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    model_buf = '0;
    test_reset();
    test_load_fast();
    test_store_wait();
    test_ready_at_limit();
    test_back_to_back();
    test_random();
    test_reset_mid_busy();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
